// File: rtl/imem_load_ctrl.sv
// Instruction-memory controller: clears the array, streams a program in over
// valid/ready, then serves zero-latency word fetches from the PC with fault checks.
module imem_load_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_start_i,
  input  logic          load_valid_i,
  input  logic [31:0]   load_data_i,
  input  logic          load_last_i,
  output logic          load_ready_o,
  input  logic [31:0]   pc_addr_i,
  input  logic          fetch_req_i,
  output logic [31:0]   instr_o,
  output logic          instr_valid_o,
  output logic          fault_o,
  output logic          stall_o,
  output logic          load_done_o,
  output logic [AW:0]   words_loaded_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_e      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW:0] words_q, words_d;
  logic        run_s;
  logic        bad_addr_s;
  logic        handshake_s;
  logic        ready_s;
  logic        we_s;
  logic [AW-1:0] addr_s;
  logic [31:0] wdata_s;

  // State, word counter and loaded-word count registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
    end
  end

  // Next-state logic and memory-port control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    words_d     = words_q;
    ready_s     = 1'b0;
    handshake_s = 1'b0;
    we_s        = 1'b0;
    addr_s      = '0;
    wdata_s     = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        we_s   = 1'b1;
        addr_s = cnt_q[AW-1:0];
        if (cnt_q == LAST_IDX) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LOAD: begin
        // Ready drops in a restart cycle so a word can never slip in alongside it
        ready_s     = ~load_start_i;
        handshake_s = load_valid_i & ready_s;
        addr_s      = cnt_q[AW-1:0];
        if (handshake_s) begin
          we_s    = 1'b1;
          wdata_s = load_data_i;
          cnt_d   = cnt_q + CNT_ONE;
          if (load_last_i || (cnt_q == LAST_IDX)) begin
            state_d = S_RUN;
            words_d = cnt_q + CNT_ONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        addr_s = pc_addr_i[AW+1:2];
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (load_start_i) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Fetch path: purely combinational from the PC through the memory read port
  always_comb begin
    run_s      = (state_q == S_RUN);
    bad_addr_s = (pc_addr_i[1:0] != 2'b00) || (pc_addr_i[31:AW+2] != '0);
  end

  assign fault_o        = run_s & fetch_req_i & bad_addr_s;
  assign instr_valid_o  = run_s & fetch_req_i & ~bad_addr_s;
  assign instr_o        = instr_valid_o ? mem_rdata_i : 32'h0000_0000;
  assign stall_o        = ~run_s;
  assign load_done_o    = run_s;
  assign load_ready_o   = ready_s;
  assign mem_we_o       = we_s;
  assign mem_addr_o     = addr_s;
  assign mem_wdata_o    = wdata_s;
  assign words_loaded_o = words_q;

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Controller for the CPU's instruction memory. It sequences memory initialisation (clear, then program load over a valid/ready stream) and arbitrates the memory's single address port between the loader and the CPU fetch path. It stalls the CPU until a program is resident, then serves word-indexed fetches from `pc_addr_i` with alignment and range checking. It sits between the program loader, the instruction memory array (combinational read, synchronous write) and the PC/decode stage.

## Interface
- `DEPTH`, 32: number of 32-bit instruction words.
- `AW`, 5: word-address width; `DEPTH` = 2^`AW`.

- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-low.
- `load_start_i`  in  1  begin or restart a program load; sampled each cycle.
- `load_valid_i`  in  1  loader word valid.
- `load_data_i`  in  32  loader instruction word.
- `load_last_i`  in  1  marks the final word of the program; qualified by the handshake.
- `load_ready_o`  out  1  controller accepts a loader word.
- `pc_addr_i`  in  32  byte address from the PC.
- `fetch_req_i`  in  1  CPU fetch request.
- `instr_o`  out  32  fetched instruction.
- `instr_valid_o`  out  1  `instr_o` is a legal fetch.
- `fault_o`  out  1  fetch is misaligned or out of range.
- `stall_o`  out  1  CPU must hold its PC.
- `load_done_o`  out  1  program resident (state RUN).
- `words_loaded_o`  out  AW+1  count of words written by the last load.
- `mem_addr_o`  out  AW  memory word address.
- `mem_we_o`  out  1  memory write enable.
- `mem_wdata_o`  out  32  memory write data.
- `mem_rdata_i`  in  32  memory combinational read data.

## Operation
- Four states: IDLE, CLEAR, LOAD, RUN. Internal counter `cnt` is AW+1 bits wide.
- Reset (`rst_i`=0 at an edge) forces IDLE with `cnt`=0 and `words_loaded_o`=0. This holds from any state, including mid-CLEAR and mid-LOAD. Memory contents are not altered.
- `load_start_i`=1 in any state: next state is CLEAR with `cnt`=0. This has priority over every other transition.
- IDLE:
  - Waits for `load_start_i`.
  - `stall_o`=1, `mem_we_o`=0, `mem_addr_o`=0.
- CLEAR:
  - Each cycle: `mem_we_o`=1, `mem_addr_o`=`cnt`[AW-1:0], `mem_wdata_o`=0, then `cnt`++.
  - After the write at `cnt`=DEPTH-1: next state LOAD with `cnt`=0.
  - Takes exactly DEPTH cycles.
- LOAD:
  - `load_ready_o` = (state==LOAD) & ~`load_start_i`. It is combinational, so no transfer occurs in a restart cycle.
  - Handshake = `load_valid_i` & `load_ready_o`. On a handshake: `mem_we_o`=1, `mem_addr_o`=`cnt`[AW-1:0], `mem_wdata_o`=`load_data_i`, then `cnt`++.
  - Handshake with `load_last_i`=1, or handshake at `cnt`=DEPTH-1: next state RUN, and `words_loaded_o` ← `cnt`+1.
  - No handshake: `mem_we_o`=0, `mem_addr_o`=`cnt`[AW-1:0], state held.
- RUN:
  - `mem_we_o`=0, `mem_addr_o`=`pc_addr_i`[AW+1:2].
  - misaligned = `pc_addr_i`[1:0]≠0; oor = `pc_addr_i`[31:AW+2]≠0.
  - `fault_o` = `fetch_req_i` & (misaligned | oor).
  - `instr_valid_o` = `fetch_req_i` & ~`fault_o`.
  - `instr_o` = `mem_rdata_i` when `instr_valid_o`, else 32'b0 (NOP).
- Outside RUN:
  - `stall_o`=1, `load_done_o`=0.
  - `instr_o`=0, `instr_valid_o`=0, `fault_o`=0, regardless of `fetch_req_i`.
- In RUN: `stall_o`=0, `load_done_o`=1.
- `mem_wdata_o`=0 whenever `mem_we_o`=0.

## Timing
- Reset values:
  - Registered: state=IDLE, `cnt`=0, `words_loaded_o`=0.
  - Derived from IDLE: `stall_o`=1, `load_ready_o`=0, `load_done_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `instr_o`=0, `instr_valid_o`=0, `fault_o`=0.
- Start to first ready: `load_start_i` at edge N → CLEAR for cycles N+1..N+DEPTH → `load_ready_o` first high in cycle N+DEPTH+1.
- Last word to RUN: final handshake in cycle M → RUN in cycle M+1, with `stall_o` low and `words_loaded_o` valid.
- Fetch latency is zero cycles in RUN. It is purely combinational from `pc_addr_i`/`fetch_req_i` through `mem_rdata_i`.
- `words_loaded_o` changes only on entry to RUN and on reset. It holds its value through CLEAR and LOAD.
- Restart or reset during LOAD discards the partial load: memory holds zeros past the last word written.

## Test plan
- Reset: hold `rst_i`=0 for 2 cycles with random inputs → every output at its reset value; `stall_o`=1; `mem_we_o` never high.
- Basic load: pulse `load_start_i`; after 32 clear writes (addr 0..31, data 0), stream 0x20080005, 0x20090003, 0x01095020 with `load_last_i` on the third word → writes to addr 0,1,2; RUN the next cycle; `words_loaded_o`=3; `stall_o`=0.
- Fetch: after the basic load, `fetch_req_i`=1 with `pc_addr_i`=8 → `instr_o`=0x01095020, `instr_valid_o`=1. With `pc_addr_i`=12 → `instr_o`=0 (cleared word), `instr_valid_o`=1.
- Faults: `pc_addr_i`=6 → `fault_o`=1, `instr_o`=0. `pc_addr_i`=128 → `fault_o`=1, `instr_o`=0. `fetch_req_i`=0 → `fault_o`=0.
- Full load with back-pressure: 32 words with `load_last_i`=0 and `load_valid_i` toggling → only handshaken words written at addr 0..31 in order; auto-RUN after word 31; `words_loaded_o`=32.
- Restart and reset mid-load:
  - After 5 words, assert `load_start_i` together with `load_valid_i` → no write that cycle; CLEAR restarts at addr 0.
  - Separately, `rst_i`=0 mid-LOAD → IDLE next cycle; `words_loaded_o`=0.
